// File: rtl/bp_io_mmio_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : bp_io_mmio_regfile                                             |
// | Brief   : Single-outstanding MMIO target backed by a 64-bit register     |
// |           bank. BP_IO_MMIO_CYCLE_CTR_EN maps a cycle counter at the top  |
// |           register index.                                                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bp_io_mmio_regfile #(
    parameter int paddr_width_p = 40,
    parameter int data_width_p  = 64,
    parameter int num_regs_p    = 16,
    localparam int lg_regs_lp   = $clog2(num_regs_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     io_cmd_wr_i,
    input  logic [paddr_width_p-1:0] io_cmd_addr_i,
    input  logic [1:0]               io_cmd_size_i,
    input  logic [data_width_p-1:0]  io_cmd_data_i,
    input  logic                     io_cmd_v_i,
    output logic                     io_cmd_yumi_o,
    output logic                     io_resp_wr_o,
    output logic [paddr_width_p-1:0] io_resp_addr_o,
    output logic [1:0]               io_resp_size_o,
    output logic [data_width_p-1:0]  io_resp_data_o,
    output logic                     io_resp_v_o,
    input  logic                     io_resp_ready_i
);

    localparam logic [0:0] E_READY = 1'b0;
    localparam logic [0:0] E_RESP  = 1'b1;
    localparam logic [lg_regs_lp-1:0] LAST_IDX = lg_regs_lp'(num_regs_p - 1);

    logic [0:0]              state_q, state_d;
    logic [data_width_p-1:0] regs_q [num_regs_p];
    logic [lg_regs_lp-1:0]   idx;
    logic [2:0]              off;
    logic [7:0]              be_base, be;
    logic [63:0]             size_mask, wdata_sh, rd_word, rd_data, wr_word;
    logic                    wr_en;

    logic                     resp_wr_q;
    logic [paddr_width_p-1:0] resp_addr_q;
    logic [1:0]               resp_size_q;
    logic [data_width_p-1:0]  resp_data_q;

`ifdef BP_IO_MMIO_CYCLE_CTR_EN
    logic [63:0] ctr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) ctr_q <= '0;
        else         ctr_q <= ctr_q + 64'd1;
    end
`endif

    // Offset is aligned down to the access size before any byte steering.
    always_comb begin
        idx = io_cmd_addr_i[3 +: lg_regs_lp];
        case (io_cmd_size_i)
            2'd0:    begin off = io_cmd_addr_i[2:0];          be_base = 8'h01; size_mask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin off = {io_cmd_addr_i[2:1], 1'b0};  be_base = 8'h03; size_mask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin off = {io_cmd_addr_i[2], 2'b00};   be_base = 8'h0F; size_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin off = 3'd0;                         be_base = 8'hFF; size_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        be       = be_base << off;
        wdata_sh = io_cmd_data_i << {off, 3'b000};
        rd_word  = regs_q[idx];
`ifdef BP_IO_MMIO_CYCLE_CTR_EN
        if (idx == LAST_IDX) rd_word = ctr_q;
        wr_en = io_cmd_yumi_o & io_cmd_wr_i & (idx != LAST_IDX);
`else
        wr_en = io_cmd_yumi_o & io_cmd_wr_i;
`endif
        rd_data = (rd_word >> {off, 3'b000}) & size_mask;
        for (int b = 0; b < 8; b++) begin
            wr_word[8*b +: 8] = be[b] ? wdata_sh[8*b +: 8] : regs_q[idx][8*b +: 8];
        end
    end

    for (genvar r = 0; r < num_regs_p; r++) begin : g_reg
        always_ff @(posedge clk_i) begin
            if (reset_i)                                   regs_q[r] <= '0;
            else if (wr_en && (idx == lg_regs_lp'(r)))     regs_q[r] <= wr_word;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= E_READY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            E_READY: if (io_cmd_yumi_o)   state_d = E_RESP;
            E_RESP:  if (io_resp_ready_i) state_d = E_READY;
            default:                      state_d = E_READY;
        endcase
    end

    always_comb begin
        io_cmd_yumi_o = io_cmd_v_i & (state_q == E_READY) & ~reset_i;
        io_resp_v_o   = (state_q == E_RESP);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resp_wr_q   <= 1'b0;
            resp_addr_q <= '0;
            resp_size_q <= 2'd0;
            resp_data_q <= '0;
        end else if (io_cmd_yumi_o) begin
            resp_wr_q   <= io_cmd_wr_i;
            resp_addr_q <= io_cmd_addr_i;
            resp_size_q <= io_cmd_size_i;
            resp_data_q <= io_cmd_wr_i ? '0 : rd_data;
        end
    end

    assign io_resp_wr_o   = resp_wr_q;
    assign io_resp_addr_o = resp_addr_q;
    assign io_resp_size_o = resp_size_q;
    assign io_resp_data_o = resp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_io_mmio_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_bp_io_mmio_regfile                                          |
// | Brief   : Directed plus randomized bench for bp_io_mmio_regfile against  |
// |           a byte-level register model.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bp_io_mmio_regfile;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        io_cmd_wr_i;
    logic [39:0] io_cmd_addr_i;
    logic [1:0]  io_cmd_size_i;
    logic [63:0] io_cmd_data_i;
    logic        io_cmd_v_i;
    logic        io_cmd_yumi_o;
    logic        io_resp_wr_o;
    logic [39:0] io_resp_addr_o;
    logic [1:0]  io_resp_size_o;
    logic [63:0] io_resp_data_o;
    logic        io_resp_v_o;
    logic        io_resp_ready_i;

    int checks = 0;
    int passes = 0;
    logic [63:0] mdl [16];

    bp_io_mmio_regfile dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .io_cmd_wr_i(io_cmd_wr_i), .io_cmd_addr_i(io_cmd_addr_i),
        .io_cmd_size_i(io_cmd_size_i), .io_cmd_data_i(io_cmd_data_i),
        .io_cmd_v_i(io_cmd_v_i), .io_cmd_yumi_o(io_cmd_yumi_o),
        .io_resp_wr_o(io_resp_wr_o), .io_resp_addr_o(io_resp_addr_o),
        .io_resp_size_o(io_resp_size_o), .io_resp_data_o(io_resp_data_o),
        .io_resp_v_o(io_resp_v_o), .io_resp_ready_i(io_resp_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Byte-wise model: aligned offset, then byte-by-byte copy.
    function automatic logic [63:0] mdl_read(input logic [39:0] a, input logic [1:0] sz);
        int n = 1 << sz;
        int o = int'(a[2:0]) - (int'(a[2:0]) % n);
        logic [63:0] w = mdl[a[6:3]];
        logic [63:0] r = 64'd0;
        for (int b = 0; b < n; b++) r[8*b +: 8] = w[8*(o+b) +: 8];
        return r;
    endfunction

    task automatic mdl_write(input logic [39:0] a, input logic [1:0] sz, input logic [63:0] d);
        int n = 1 << sz;
        int o = int'(a[2:0]) - (int'(a[2:0]) % n);
        for (int b = 0; b < n; b++) mdl[a[6:3]][8*(o+b) +: 8] = d[8*b +: 8];
    endtask

    // Starts one posedge+1 into the accept cycle; returns one posedge+1 after the response is taken.
    task automatic do_cmd(input logic wr, input logic [39:0] a, input logic [1:0] sz,
                          input logic [63:0] d, input int hold, output logic [63:0] rdata);
        io_resp_ready_i = (hold == 0);
        io_cmd_wr_i = wr; io_cmd_addr_i = a; io_cmd_size_i = sz; io_cmd_data_i = d;
        io_cmd_v_i = 1'b1;
        #1 chk("yumi", 64'(io_cmd_yumi_o), 64'd1);
        @(posedge clk_i); #1;
        io_cmd_v_i = 1'b0;
        chk("resp_v", 64'(io_resp_v_o), 64'd1);
        chk("resp_addr", 64'(io_resp_addr_o), 64'(a));
        chk("resp_hdr", {62'd0, io_resp_size_o} | 64'(io_resp_wr_o) << 2, {62'd0, sz} | 64'(wr) << 2);
        rdata = io_resp_data_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk("hold_data", io_resp_data_o, rdata);
        end
        io_resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("resp_taken", 64'(io_resp_v_o), 64'd0);
    endtask

    initial begin
        logic [63:0] rd, exp_a, v1, v2;
        logic [39:0] a;
        logic [1:0]  sz;
        logic        wr;

        reset_i = 1'b1; io_cmd_v_i = 1'b1; io_cmd_wr_i = 1'b0; io_cmd_addr_i = '0;
        io_cmd_size_i = 2'd3; io_cmd_data_i = '0; io_resp_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) mdl[i] = 64'd0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_yumi", 64'(io_cmd_yumi_o), 64'd0);
        chk("rst_resp_v", 64'(io_resp_v_o), 64'd0);
        chk("rst_resp_data", io_resp_data_o, 64'd0);
        chk("rst_resp_hdr", {io_resp_addr_o, io_resp_size_o, io_resp_wr_o}, 64'd0);
        reset_i = 1'b0; io_cmd_v_i = 1'b0;
        @(posedge clk_i); #1;

        do_cmd(1'b1, 40'h08, 2'd3, 64'h1122334455667788, 0, rd);
        mdl_write(40'h08, 2'd3, 64'h1122334455667788);
        chk("wr_data_zero", rd, 64'd0);
        do_cmd(1'b0, 40'h08, 2'd3, 64'd0, 0, rd);
        chk("rd8", rd, 64'h1122334455667788);

        do_cmd(1'b1, 40'h0B, 2'd0, 64'h00000000000000AB, 0, rd);
        mdl_write(40'h0B, 2'd0, 64'hAB);
        do_cmd(1'b0, 40'h08, 2'd2, 64'd0, 0, rd);
        chk("rd4_after_byte", rd, 64'hAB667788);
        do_cmd(1'b0, 40'h0F, 2'd1, 64'd0, 0, rd);
        chk("rd2_misaligned", rd, 64'h1122);

        do_cmd(1'b1, 40'h1008, 2'd3, 64'hDEAD, 0, rd);
        mdl_write(40'h1008, 2'd3, 64'hDEAD);
        do_cmd(1'b0, 40'h08, 2'd3, 64'd0, 0, rd);
        chk("alias", rd, 64'hDEAD);

        // Backpressure with a second command waiting.
        io_resp_ready_i = 1'b0;
        io_cmd_wr_i = 1'b0; io_cmd_addr_i = 40'h08; io_cmd_size_i = 2'd3; io_cmd_v_i = 1'b1;
        #1 chk("bp_yumi_a", 64'(io_cmd_yumi_o), 64'd1);
        @(posedge clk_i); #1;
        io_cmd_wr_i = 1'b0; io_cmd_addr_i = 40'h0C; io_cmd_size_i = 2'd2; io_cmd_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_no_yumi", 64'(io_cmd_yumi_o), 64'd0);
            chk("bp_resp_v", 64'(io_resp_v_o), 64'd1);
            chk("bp_data_stable", io_resp_data_o, 64'hDEAD);
            chk("bp_addr_stable", 64'(io_resp_addr_o), 64'h08);
            @(posedge clk_i); #1;
        end
        io_resp_ready_i = 1'b1;
        #1 chk("bp_still_held", 64'(io_cmd_yumi_o), 64'd0);
        @(posedge clk_i); #1;
        chk("bp_taken", 64'(io_resp_v_o), 64'd0);
        chk("bp_yumi_b", 64'(io_cmd_yumi_o), 64'd1);
        @(posedge clk_i); #1;
        io_cmd_v_i = 1'b0;
        chk("bp_resp_b", io_resp_data_o, mdl_read(40'h0C, 2'd2));
        @(posedge clk_i); #1;

        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = {8'($urandom), 32'($urandom)};
`ifdef BP_IO_MMIO_CYCLE_CTR_EN
            if (a[6:3] == 4'hF) a[6:3] = 4'hE;
`endif
            exp_a = wr ? 64'd0 : mdl_read(a, sz);
            v1 = {$urandom, $urandom};
            do_cmd(wr, a, sz, v1, $urandom_range(0, 3), rd);
            if (wr) mdl_write(a, sz, v1);
            chk("rand_resp", rd, exp_a);
        end

        // Reset while a response is pending.
        io_resp_ready_i = 1'b0;
        io_cmd_wr_i = 1'b1; io_cmd_addr_i = 40'h10; io_cmd_size_i = 2'd3;
        io_cmd_data_i = 64'h5A5A5A5A5A5A5A5A; io_cmd_v_i = 1'b1;
        @(posedge clk_i); #1;
        io_cmd_v_i = 1'b0;
        chk("pend_resp_v", 64'(io_resp_v_o), 64'd1);
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0; io_resp_ready_i = 1'b1;
        chk("rst_pend_v", 64'(io_resp_v_o), 64'd0);
        chk("rst_pend_hdr", {io_resp_addr_o, io_resp_size_o, io_resp_wr_o}, 64'd0);
        for (int i = 0; i < 16; i++) mdl[i] = 64'd0;
        repeat (3) begin
            @(posedge clk_i); #1;
            chk("no_stale_resp", 64'(io_resp_v_o), 64'd0);
        end
        for (int i = 0; i < 15; i++) begin
            do_cmd(1'b0, 40'(i * 8), 2'd3, 64'd0, 0, rd);
            chk("post_rst_zero", rd, 64'd0);
        end
`ifndef BP_IO_MMIO_CYCLE_CTR_EN
        do_cmd(1'b0, 40'h78, 2'd3, 64'd0, 0, rd);
        chk("post_rst_zero15", rd, 64'd0);
        do_cmd(1'b1, 40'h78, 2'd3, 64'hFFFF, 0, rd);
        do_cmd(1'b0, 40'h78, 2'd3, 64'd0, 0, rd);
        chk("reg15_rw", rd, 64'hFFFF);
`else
        do_cmd(1'b1, 40'h78, 2'd3, 64'hFFFF, 0, rd);
        do_cmd(1'b0, 40'h78, 2'd3, 64'd0, 0, v1);
        repeat (8) @(posedge clk_i);
        do_cmd(1'b0, 40'h78, 2'd3, 64'd0, 0, v2);
        chk("ctr_delta", v2 - v1, 64'd10);
        chk("ctr_unwritten", 64'(v1 < 64'd1000), 64'd1);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
